// File: rtl/ecc_scrubber_pkg.sv
// Shared types and widths for the SECDED(72,64) background scrubber.
package ecc_scrubber_pkg;

    localparam int unsigned DataWidth     = 64;
    localparam int unsigned ProtWidth     = 72;
    localparam int unsigned SyndromeWidth = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWait  = 2'd2,
        StWrite = 2'd3
    } scrub_state_e;

endpackage

// File: rtl/prim_secded_72_64.sv
// SECDED(72,64) Hsiao-style encoder/decoder. Data columns are distinct odd-weight
// syndromes, so single errors give odd syndromes and double errors give even non-zero ones.
package prim_secded_72_64_pkg;

    // The 56 weight-3 bytes in ascending order, followed by the 8 smallest weight-5 bytes.
    function automatic logic [63:0][7:0] secded_cols();
        logic [63:0][7:0] cols;
        logic [7:0]       v;
        int               n;
        cols = '0;
        n    = 0;
        for (int w = 3; w <= 5; w += 2) begin
            for (int i = 0; i < 256; i++) begin
                v = 8'(i);
                if ($countones(v) == w && n < 64) begin
                    cols[n] = v;
                    n++;
                end
            end
        end
        return cols;
    endfunction

    localparam logic [63:0][7:0] Cols = secded_cols();

endpackage

module prim_secded_72_64_enc
    import prim_secded_72_64_pkg::*;
(
    input  logic [63:0] data_i,
    output logic [71:0] data_o
);
    logic [7:0] chk;

    always_comb begin
        chk = '0;
        for (int i = 0; i < 64; i++) begin
            if (data_i[i]) chk ^= Cols[i];
        end
        data_o = {chk, data_i};
    end
endmodule

module prim_secded_72_64_dec
    import prim_secded_72_64_pkg::*;
(
    input  logic [71:0] data_i,
    output logic [63:0] data_o,
    output logic [1:0]  err_o
);
    logic [7:0] syndrome;

    always_comb begin
        syndrome = data_i[71:64];
        for (int i = 0; i < 64; i++) begin
            if (data_i[i]) syndrome ^= Cols[i];
        end
        for (int i = 0; i < 64; i++) begin
            data_o[i] = data_i[i] ^ (syndrome == Cols[i]);
        end
        err_o = {~(^syndrome) & (|syndrome), ^syndrome};
    end
endmodule

// File: rtl/ecc_scrubber_72_64.sv
// Background scrubber: reads one bank word per trigger, writes back corrected single-bit
// errors, and reports/counts corrected and uncorrectable errors.
module ecc_scrubber_72_64
    import ecc_scrubber_pkg::*;
#(
    parameter int unsigned BankSize  = 256,
    parameter int unsigned AddrWidth = $clog2(BankSize),
    parameter int unsigned CntWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 scrub_trigger_i,
    output logic                 bank_req_o,
    output logic                 bank_we_o,
    output logic [AddrWidth-1:0] bank_add_o,
    output logic [ProtWidth-1:0] bank_wdata_o,
    input  logic                 bank_gnt_i,
    input  logic                 bank_rvalid_i,
    input  logic [ProtWidth-1:0] bank_rdata_i,
    output logic                 busy_o,
    output logic                 corrected_o,
    output logic                 uncorrectable_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [CntWidth-1:0]  corr_cnt_o,
    output logic [CntWidth-1:0]  uncorr_cnt_o
);
    scrub_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_next;
    logic [DataWidth-1:0] data_q, dec_data;
    logic [ProtWidth-1:0] enc_data;
    logic [1:0]           dec_err;
    logic                 advance, latch_data, corr_evt, uncorr_evt;

    prim_secded_72_64_dec u_dec (
        .data_i (bank_rdata_i),
        .data_o (dec_data),
        .err_o  (dec_err)
    );

    prim_secded_72_64_enc u_enc (
        .data_i (data_q),
        .data_o (enc_data)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d    = state_q;
        advance    = 1'b0;
        latch_data = 1'b0;
        corr_evt   = 1'b0;
        uncorr_evt = 1'b0;
        bank_req_o = 1'b0;
        bank_we_o  = 1'b0;
        case (state_q)
            StIdle: if (scrub_trigger_i) state_d = StRead;
            StRead: begin
                bank_req_o = 1'b1;
                if (bank_gnt_i) state_d = StWait;
            end
            StWait: if (bank_rvalid_i) begin
                case (dec_err)
                    2'b00: begin
                        advance = 1'b1;
                        state_d = StIdle;
                    end
                    2'b01: begin
                        latch_data = 1'b1;
                        corr_evt   = 1'b1;
                        state_d    = StWrite;
                    end
                    default: begin
                        advance    = 1'b1;
                        uncorr_evt = 1'b1;
                        state_d    = StIdle;
                    end
                endcase
            end
            StWrite: begin
                bank_req_o = 1'b1;
                bank_we_o  = 1'b1;
                if (bank_gnt_i) begin
                    advance = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign addr_next    = (addr_q == AddrWidth'(BankSize - 1)) ? '0 : addr_q + 1'b1;
    assign bank_add_o   = addr_q;
    assign bank_wdata_o = (state_q == StWrite) ? enc_data : '0;
    assign busy_o       = (state_q != StIdle);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            corrected_o     <= 1'b0;
            uncorrectable_o <= 1'b0;
            err_addr_o      <= '0;
            corr_cnt_o      <= '0;
            uncorr_cnt_o    <= '0;
        end else begin
            state_q         <= state_d;
            corrected_o     <= corr_evt;
            uncorrectable_o <= uncorr_evt;
            if (advance) addr_q <= addr_next;
            if (corr_evt || uncorr_evt) err_addr_o <= addr_q;
            if (corr_evt && corr_cnt_o != '1) corr_cnt_o <= corr_cnt_o + 1'b1;
            if (uncorr_evt && uncorr_cnt_o != '1) uncorr_cnt_o <= uncorr_cnt_o + 1'b1;
        end
    end

    // NOTE: pure datapath register, always loaded before WRITE consumes it, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (latch_data) data_q <= dec_data;
    end

endmodule

// File: tb/tb_ecc_scrubber_72_64.sv
// Directed bench for ecc_scrubber_72_64: a 256-word instance for the main flows and a
// 4-word / 2-bit-counter instance for address wrap and counter saturation.
module tb_ecc_scrubber_72_64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 256-word instance
    logic        rst_a, trig_a, gnt_a, rvalid_a;
    logic [71:0] rdata_a, wdata_a;
    logic        req_a, we_a, busy_a, corrected_a, uncorr_a;
    logic [7:0]  add_a, err_addr_a;
    logic [15:0] corr_cnt_a, uncorr_cnt_a;

    // 4-word instance
    logic        rst_b, trig_b, gnt_b, rvalid_b;
    logic [71:0] rdata_b, wdata_b;
    logic        req_b, we_b, busy_b, corrected_b, uncorr_b;
    logic [1:0]  add_b, err_addr_b;
    logic [1:0]  corr_cnt_b, uncorr_cnt_b;

    ecc_scrubber_72_64 dut_a (
        .clk_i (clk), .rst_i (rst_a), .scrub_trigger_i (trig_a),
        .bank_req_o (req_a), .bank_we_o (we_a), .bank_add_o (add_a), .bank_wdata_o (wdata_a),
        .bank_gnt_i (gnt_a), .bank_rvalid_i (rvalid_a), .bank_rdata_i (rdata_a),
        .busy_o (busy_a), .corrected_o (corrected_a), .uncorrectable_o (uncorr_a),
        .err_addr_o (err_addr_a), .corr_cnt_o (corr_cnt_a), .uncorr_cnt_o (uncorr_cnt_a)
    );

    ecc_scrubber_72_64 #(.BankSize(4), .CntWidth(2)) dut_b (
        .clk_i (clk), .rst_i (rst_b), .scrub_trigger_i (trig_b),
        .bank_req_o (req_b), .bank_we_o (we_b), .bank_add_o (add_b), .bank_wdata_o (wdata_b),
        .bank_gnt_i (gnt_b), .bank_rvalid_i (rvalid_b), .bank_rdata_i (rdata_b),
        .busy_o (busy_b), .corrected_o (corrected_b), .uncorrectable_o (uncorr_b),
        .err_addr_o (err_addr_b), .corr_cnt_o (corr_cnt_b), .uncorr_cnt_o (uncorr_cnt_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference code: weight-3 columns enumerated by bit triples, then a fixed weight-5 list.
    function automatic logic [7:0] ref_col(input int i);
        logic [7:0] c;
        int         n;
        c = '0;
        n = 0;
        case (i)
            56: c = 8'h1F;
            57: c = 8'h2F;
            58: c = 8'h37;
            59: c = 8'h3B;
            60: c = 8'h3D;
            61: c = 8'h3E;
            62: c = 8'h4F;
            63: c = 8'h57;
            default: begin
                for (int hi = 2; hi < 8; hi++)
                    for (int mid = 1; mid < hi; mid++)
                        for (int lo = 0; lo < mid; lo++) begin
                            if (n == i) c = 8'((1 << hi) | (1 << mid) | (1 << lo));
                            n++;
                        end
            end
        endcase
        return c;
    endfunction

    function automatic logic [71:0] ref_enc(input logic [63:0] d);
        logic [7:0] chk;
        chk = '0;
        for (int i = 0; i < 64; i++) if (d[i]) chk ^= ref_col(i);
        return {chk, d};
    endfunction

    logic [71:0] bank_a [256];
    logic [71:0] bank_b [4];
    logic [63:0] orig5;

    // Observations gathered by step_a
    int          rd_cnt = 0, wr_cnt = 0;
    int          corr_pulses, uncorr_pulses, busy_cycles, unstable;
    logic [7:0]  rd_addr, wr_addr;
    logic [71:0] wr_data;

    task automatic tally_a();
        if (busy_a) busy_cycles++;
        if (corrected_a) corr_pulses++;
        if (uncorr_a) uncorr_pulses++;
    endtask

    // One scrub step on instance A: trigger, grant after gnt_wait cycles, return data after
    // rv_wait further cycles, grant any write-back, then one idle cycle.
    task automatic step_a(input int gnt_wait, input int rv_wait, input bit extra);
        logic [7:0] a0;
        corr_pulses = 0; uncorr_pulses = 0; busy_cycles = 0; unstable = 0;
        trig_a = 1'b1;
        @(negedge clk); trig_a = 1'b0; tally_a();
        a0 = add_a;
        if (!req_a || we_a) unstable++;
        for (int k = 0; k < gnt_wait; k++) begin
            trig_a = extra;
            @(negedge clk); trig_a = 1'b0; tally_a();
            if (!req_a || we_a || add_a !== a0) unstable++;
        end
        gnt_a = 1'b1; rd_addr = add_a; rd_cnt++;
        @(negedge clk); gnt_a = 1'b0; tally_a();
        if (req_a) unstable++;
        for (int k = 0; k < rv_wait; k++) begin
            trig_a = extra;
            @(negedge clk); trig_a = 1'b0; tally_a();
            if (req_a) unstable++;
        end
        rvalid_a = 1'b1; rdata_a = bank_a[rd_addr];
        @(negedge clk); rvalid_a = 1'b0; rdata_a = '0; tally_a();
        for (int k = 0; k < 8 && req_a; k++) begin
            if (we_a) begin
                wr_cnt++; wr_addr = add_a; wr_data = wdata_a;
            end
            gnt_a = 1'b1;
            @(negedge clk); gnt_a = 1'b0; tally_a();
        end
        @(negedge clk); tally_a();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_addr_b;
        int         seen_b;

        for (int i = 0; i < 256; i++) bank_a[i] = ref_enc({32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101});
        bank_a[0] = ref_enc(64'hDEAD_BEEF_0123_4567);
        orig5 = bank_a[5][63:0];
        bank_a[5] = bank_a[5] ^ (72'd1 << 17);
        bank_a[6] = bank_a[6] ^ (72'd1 << 3) ^ (72'd1 << 40);
        for (int k = 0; k < 4; k++)
            bank_b[k] = ref_enc(64'h1357_9BDF_0000_0000 + 64'(k) * 64'h0000_0000_1111_1111) ^ (72'd1 << (k * 17 + 2));

        rst_a = 1'b1; trig_a = 1'b0; gnt_a = 1'b0; rvalid_a = 1'b0; rdata_a = '0;
        rst_b = 1'b1; trig_b = 1'b0; gnt_b = 1'b0; rvalid_b = 1'b0; rdata_b = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", busy_a, 0);
        check("rst_req", req_a, 0);
        check("rst_we", we_a, 0);
        check("rst_wdata", wdata_a, 0);
        check("rst_addr", add_a, 0);
        check("rst_pulses", {corrected_a, uncorr_a}, 0);
        check("rst_err_addr", err_addr_a, 0);
        check("rst_cnts", {corr_cnt_a, uncorr_cnt_a}, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // 1: clean word at address 0
        step_a(0, 0, 0);
        check("t1_rd_addr", rd_addr, 0);
        check("t1_no_write", wr_cnt, 0);
        check("t1_no_pulses", corr_pulses + uncorr_pulses, 0);
        check("t1_cnts", {corr_cnt_a, uncorr_cnt_a}, 0);
        check("t1_busy_cycles", busy_cycles, 2);
        check("t1_addr_next", add_a, 1);
        check("t1_wdata_idle", wdata_a, 0);

        for (int i = 1; i < 5; i++) step_a(0, 0, 0);
        check("walk_addr", add_a, 5);

        // 2: single-bit error at address 5
        step_a(0, 0, 0);
        check("t2_corr_pulse", corr_pulses, 1);
        check("t2_uncorr_pulse", uncorr_pulses, 0);
        check("t2_err_addr", err_addr_a, 5);
        check("t2_corr_cnt", corr_cnt_a, 1);
        check("t2_wr_cnt", wr_cnt, 1);
        check("t2_wr_addr", wr_addr, 5);
        check("t2_wr_data", wr_data, ref_enc(orig5));
        check("t2_busy_cycles", busy_cycles, 3);
        check("t2_addr_next", add_a, 6);

        // 3: double-bit error at address 6
        step_a(0, 0, 0);
        check("t3_uncorr_pulse", uncorr_pulses, 1);
        check("t3_corr_pulse", corr_pulses, 0);
        check("t3_uncorr_cnt", uncorr_cnt_a, 1);
        check("t3_corr_cnt", corr_cnt_a, 1);
        check("t3_no_write", wr_cnt, 1);
        check("t3_err_addr", err_addr_a, 6);
        check("t3_addr_next", add_a, 7);

        // 5: stalls with triggers arriving while busy
        step_a(10, 4, 1);
        check("t5_stable", unstable, 0);
        check("t5_busy_cycles", busy_cycles, 16);
        check("t5_one_read", rd_cnt, 8);
        check("t5_rd_addr", rd_addr, 7);
        check("t5_addr_next", add_a, 8);
        repeat (3) @(negedge clk);
        check("t5_no_queued_trigger", {busy_a, req_a}, 0);
        rvalid_a = 1'b1; rdata_a = bank_a[6];
        @(negedge clk); rvalid_a = 1'b0; rdata_a = '0;
        @(negedge clk);
        check("t5_idle_rvalid_ignored", {busy_a, uncorr_a, uncorr_cnt_a}, 72'h1);

        // 4: wrap and saturation on the 4-word instance
        for (int s = 0; s < 5; s++) begin
            exp_addr_b = 2'(s % 4);
            seen_b = 0;
            trig_b = 1'b1;
            @(negedge clk); trig_b = 1'b0;
            check("t4_rd_addr", add_b, exp_addr_b);
            gnt_b = 1'b1;
            @(negedge clk); gnt_b = 1'b0;
            rvalid_b = 1'b1; rdata_b = bank_b[exp_addr_b];
            @(negedge clk); rvalid_b = 1'b0; rdata_b = '0;
            if (corrected_b) seen_b++;
            for (int k = 0; k < 8 && req_b; k++) begin
                gnt_b = 1'b1;
                @(negedge clk); gnt_b = 1'b0;
            end
            if (s == 2) check("t4_cnt_at_3", corr_cnt_b, 3);
            if (s == 4) begin
                check("t4_pulse_saturated", seen_b, 1);
                check("t4_cnt_saturated", corr_cnt_b, 3);
                check("t4_err_addr", err_addr_b, 0);
            end
        end
        check("t4_addr_wrapped", add_b, 1);

        // 6: reset mid-operation
        trig_a = 1'b1;
        @(negedge clk); trig_a = 1'b0;
        check("t6_req_in_read", req_a, 1);
        rst_a = 1'b1;
        #1;
        check("t6_req_async_drop", req_a, 0);
        check("t6_addr_async", add_a, 0);
        @(negedge clk); rst_a = 1'b0;
        @(negedge clk);
        trig_a = 1'b1;
        @(negedge clk); trig_a = 1'b0; gnt_a = 1'b1;
        @(negedge clk); gnt_a = 1'b0;
        check("t6_in_wait", {busy_a, req_a}, 2'b10);
        rst_a = 1'b1;
        #1;
        check("t6_idle_after_rst", {busy_a, req_a}, 0);
        @(negedge clk); rst_a = 1'b0;
        rvalid_a = 1'b1; rdata_a = bank_a[5];
        @(negedge clk); rvalid_a = 1'b0; rdata_a = '0;
        check("t6_late_rvalid_no_pulse", {corrected_a, uncorr_a}, 0);
        check("t6_late_rvalid_no_count", {corr_cnt_a, uncorr_cnt_a}, 0);
        @(negedge clk);
        check("t6_still_idle", {busy_a, req_a, add_a}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
